plab5_mcore_mem_req_cmsg_queue: RTL

Two-entry buffering stage directly downstream of the memory-request control-message packer. It accepts a packed control message (type/opaque/addr/len) plus the matching data word, stores both together, and issues the reassembled full memory request to the cache/network side. Flow control is val/rdy on both ends. Every entry leaves in the order it arrived.

---
 rtl/plab5_mcore_mem_req_cmsg_queue.sv | 67 ++++++
 1 files changed

// File: rtl/plab5_mcore_mem_req_cmsg_queue.sv
// Two-entry in-order buffer that pairs a packed memory-request control message
// with its data word and presents the reassembled request downstream.
module plab5_mcore_mem_req_cmsg_queue #(
    parameter int unsigned p_opaque_nbits = 8,
    parameter int unsigned p_addr_nbits   = 32,
    parameter int unsigned p_data_nbits   = 32,
    localparam int unsigned l = $clog2(p_data_nbits / 8),
    localparam int unsigned c = 3 + p_opaque_nbits + p_addr_nbits + l,
    localparam int unsigned m = c + p_data_nbits
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enq_val,
    output logic                    enq_rdy,
    input  logic [c-1:0]            enq_cmsg,
    input  logic [p_data_nbits-1:0] enq_data,
    output logic                    deq_val,
    input  logic                    deq_rdy,
    output logic [m-1:0]            deq_msg,
    output logic [2:0]              deq_type,
    output logic [p_addr_nbits-1:0] deq_addr,
    output logic [1:0]              num_free
);

    logic [m-1:0] entries [2];
    logic         head;
    logic         tail;
    logic [1:0]   count;
    logic         enq_fire;
    logic         deq_fire;

    // Ready/valid depend only on registered count, so there is no
    // combinational path between the two ends.
    assign enq_rdy  = (count != 2'd2);
    assign deq_val  = (count != 2'd0);
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;

    assign deq_msg  = entries[head];
    assign deq_type = deq_msg[m-1 -: 3];
    assign deq_addr = deq_msg[p_data_nbits + l + p_addr_nbits - 1 -: p_addr_nbits];
    assign num_free = 2'd2 - count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head       <= 1'b0;
            tail       <= 1'b0;
            count      <= '0;
            entries[0] <= '0;
            entries[1] <= '0;
        end else begin
            if (enq_fire) begin
                entries[tail] <= {enq_cmsg, enq_data};
                tail          <= ~tail;
            end
            if (deq_fire) begin
                head <= ~head;
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
